pulse_qualifier: RTL and testbench

- Upstream stage of evt_counter in the receive-signal test path.
- Takes the raw, asynchronous receiver/photodiode comparator line and synchronises it into clk_in.
- Rejects runt pulses and enforces a dead time after each pulse.
- Emits exactly one single-cycle evt_out per qualified pulse; evt_out drives evt_counter's evt_in directly.

---
 rtl/pulse_qualifier.sv | 163 ++++++++++++++++
 tb/tb_pulse_qualifier.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_qualifier.sv
// Qualifies pulses on an asynchronous receiver line: synchronise, reject runts, enforce dead time.
// Optional width measurement is built when PULSE_WIDTH_MEAS_EN is defined.
module pulse_qualifier #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 4,
    parameter int HOLDOFF     = 16,
    parameter int WIDTH_W     = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               sig_in,
    input  logic               enable_in,
    output logic               evt_out,
    output logic               glitch_out,
    output logic               busy_out,
    output logic [WIDTH_W-1:0] width_out,
    output logic               width_valid_out
);
    localparam int RUN_W  = $clog2(MIN_WIDTH + 1);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MIN_WIDTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

    typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   evt_q, evt_d;
    logic                   glitch_q, glitch_d;
    logic                   busy_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q   <= '0;
            s_d_q    <= 1'b0;
            state_q  <= IDLE;
            run_q    <= '0;
            hold_q   <= '0;
            evt_q    <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q    <= s;
            state_q  <= state_d;
            run_q    <= run_d;
            hold_q   <= hold_d;
            evt_q    <= evt_d;
            glitch_q <= glitch_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        hold_d   = hold_q;
        evt_d    = 1'b0;
        glitch_d = 1'b0;
        if (!enable_in) begin
            state_d = IDLE;
            run_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = QUALIFY;
                        run_d   = RUN_W'(1);
                    end
                end
                QUALIFY: begin
                    // A full run already counted qualifies even if the line has just dropped.
                    if (run_q == RUN_MAX) begin
                        evt_d   = 1'b1;
                        state_d = ACTIVE;
                    end else if (!s) begin
                        glitch_d = 1'b1;
                        state_d  = IDLE;
                        run_d    = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!s) begin
                        run_d = '0;
                        if (HOLDOFF == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = HOLD;
                            hold_d  = HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_q == '0 || hold_q == HOLD_W'(1)) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign evt_out    = evt_q;
    assign glitch_out = glitch_q;
    assign busy_out   = busy_q;

`ifdef PULSE_WIDTH_MEAS_EN
    localparam logic [WIDTH_W-1:0] WCNT_MAX = '1;

    logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
    logic [WIDTH_W-1:0] width_q;
    logic               wvalid_q;
    logic               exit_active;

    assign exit_active = enable_in && (state_q == ACTIVE) && !s;

    always_comb begin
        wcnt_d = wcnt_q;
        if (!enable_in) begin
            wcnt_d = '0;
        end else if (state_q == IDLE) begin
            wcnt_d = rise ? WIDTH_W'(1) : '0;
        end else if ((state_q == QUALIFY || state_q == ACTIVE) && s && wcnt_q != WCNT_MAX) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wcnt_q   <= '0;
            width_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            wvalid_q <= exit_active;
            if (exit_active) begin
                width_q <= wcnt_q;
            end
        end
    end

    assign width_out       = width_q;
    assign width_valid_out = wvalid_q;
`else
    assign width_out       = '0;
    assign width_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_qualifier.sv
// Bench for pulse_qualifier: directed reset/latency/holdoff/enable steps plus random pulse trains
// checked against a pulse-level reference model.
module tb_pulse_qualifier;
    localparam int S = 2;
    localparam int M = 4;
    localparam int H = 16;
`ifdef PULSE_WIDTH_MEAS_EN
    localparam int WW = 4;
`else
    localparam int WW = 16;
`endif
    localparam int WMAX = (1 << WW) - 1;
    localparam int NMAX = 700;

    logic          clk;
    logic          rst;
    logic          sig;
    logic          en;
    logic          evt;
    logic          glitch;
    logic          busy;
    logic [WW-1:0] width;
    logic          wvalid;

    pulse_qualifier #(
        .SYNC_STAGES(S),
        .MIN_WIDTH  (M),
        .HOLDOFF    (H),
        .WIDTH_W    (WW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .sig_in         (sig),
        .enable_in      (en),
        .evt_out        (evt),
        .glitch_out     (glitch),
        .busy_out       (busy),
        .width_out      (width),
        .width_valid_out(wvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bit          sig_arr[NMAX];
    bit          en_arr[NMAX];
    bit          exp_evt[NMAX];
    bit          exp_glitch[NMAX];
    bit          exp_busy[NMAX];
    bit          exp_wv[NMAX];
    int          wval[NMAX];
    int          exp_w[NMAX];
    logic [31:0] exp_q[$];
    int          w_hold = 0;
    int          checks = 0;
    int          failures = 0;
    int          seg_evt, seg_glitch, seg_wv, first_evt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int e = 0; e < NMAX; e++) begin
            sig_arr[e] = 1'b0;
            en_arr[e]  = 1'b1;
        end
    endtask

    task automatic set_high(input int from, input int len);
        for (int e = from; e < from + len; e++) sig_arr[e] = 1'b1;
    endtask

    // Pulse-level model: each high run of sig_arr is either detected (if the block is armed
    // when its synchronised rise arrives) or lost; detected runs qualify or glitch by length.
    task automatic build_model(input int n);
        int t, l, x, rdy, w;
        exp_q.delete();
        for (int e = 0; e < NMAX; e++) begin
            exp_evt[e] = 0; exp_glitch[e] = 0; exp_busy[e] = 0;
            exp_wv[e] = 0; wval[e] = 0; exp_w[e] = 0;
        end
        t = 0;
        rdy = 0;
        while (t < n) begin
            if (!sig_arr[t]) begin
                t++;
                continue;
            end
            l = 0;
            while (t + l < n && sig_arr[t + l]) l++;
            if (t + S >= rdy) begin
                if (l >= M) begin
                    x = (t + l + S > t + S + M + 1) ? t + l + S : t + S + M + 1;
                    exp_evt[t + S + M] = 1;
                    exp_q.push_back(t + S + M);
`ifdef PULSE_WIDTH_MEAS_EN
                    exp_wv[x] = 1;
                    wval[x] = (l > WMAX) ? WMAX : l;
`endif
                    rdy = x + H + 1;
                end else begin
                    exp_glitch[t + S + l] = 1;
                    rdy = t + S + l + 1;
                end
                for (int e = t + S; e <= rdy - 2; e++) exp_busy[e] = 1;
            end
            t += l;
        end
        w = w_hold;
        for (int e = 0; e < n; e++) begin
            if (exp_wv[e]) w = wval[e];
            exp_w[e] = w;
        end
        w_hold = w;
    endtask

    task automatic run_seg(input int n, input bit use_model);
        seg_evt = 0; seg_glitch = 0; seg_wv = 0; first_evt = -1;
        if (use_model) build_model(n);
        for (int e = 0; e < n; e++) begin
            sig = sig_arr[e];
            en  = en_arr[e];
            @(posedge clk);
            #1;
            if (evt === 1'b1) begin
                seg_evt++;
                if (first_evt < 0) first_evt = e;
                if (use_model) begin
                    if (exp_q.size() == 0) chk("evt_unexpected", e, 32'hFFFF_FFFF);
                    else chk("evt_edge", e, exp_q.pop_front());
                end
            end
            if (glitch === 1'b1) seg_glitch++;
            if (wvalid === 1'b1) seg_wv++;
            if (use_model) begin
                chk("evt", evt, exp_evt[e]);
                chk("glitch", glitch, exp_glitch[e]);
                chk("busy", busy, exp_busy[e]);
                chk("width_valid", wvalid, exp_wv[e]);
                chk("width", width, exp_w[e]);
            end
        end
        if (use_model) chk("evt_q_empty", exp_q.size(), 0);
        sig = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        sig = 1'b0;
        en  = 1'b1;

        // Reset held with the line toggling: everything stays clear.
        for (int i = 0; i < 10; i++) begin
            sig = i[0];
            @(posedge clk);
            #1;
            chk("rst_hold_flags", {28'd0, evt, glitch, busy, wvalid}, 0);
            chk("rst_hold_width", width, 0);
        end
        sig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stim();
        run_seg(10, 1);

        // 10-cycle pulse: one event right after edge S+M.
        clear_stim();
        set_high(0, 10);
        run_seg(50, 1);
        chk("lat_first_evt", first_evt, 6);
        chk("lat_evt_count", seg_evt, 1);
        chk("lat_glitch_count", seg_glitch, 0);

        // 3-cycle runt.
        clear_stim();
        set_high(0, 3);
        run_seg(40, 1);
        chk("runt_glitch_count", seg_glitch, 1);
        chk("runt_evt_count", seg_evt, 0);

        // Exactly MIN_WIDTH qualifies.
        clear_stim();
        set_high(0, M);
        run_seg(40, 1);
        chk("minw_evt_count", seg_evt, 1);

        // Two 8-cycle pulses 5 apart, then 30 apart.
        clear_stim();
        set_high(0, 8);
        set_high(13, 8);
        run_seg(60, 1);
        chk("hold_close_evt_count", seg_evt, 1);
        clear_stim();
        set_high(0, 8);
        set_high(38, 8);
        run_seg(90, 1);
        chk("hold_far_evt_count", seg_evt, 2);

        // Line held high for 100 cycles.
        clear_stim();
        set_high(0, 100);
        run_seg(140, 1);
        chk("edge_only_evt_count", seg_evt, 1);

        // Width measurement: 9-cycle and 40-cycle pulses.
        clear_stim();
        set_high(0, 9);
        run_seg(40, 1);
`ifdef PULSE_WIDTH_MEAS_EN
        chk("width9", width, 9);
        chk("width9_valid_count", seg_wv, 1);
`else
        chk("width9", width, 0);
        chk("width9_valid_count", seg_wv, 0);
`endif
        clear_stim();
        set_high(0, 40);
        run_seg(80, 1);
`ifdef PULSE_WIDTH_MEAS_EN
        chk("width40_sat", width, 15);
`else
        chk("width40_sat", width, 0);
`endif

        // Enable dropped mid-QUALIFY, re-raised while the line is still high.
        clear_stim();
        set_high(0, 20);
        en_arr[3] = 1'b0;
        en_arr[4] = 1'b0;
        en_arr[5] = 1'b0;
        run_seg(50, 0);
        chk("en_evt_count", seg_evt, 0);
        chk("en_glitch_count", seg_glitch, 0);
        clear_stim();
        set_high(0, 10);
        run_seg(50, 1);
        chk("en_next_edge_evt_count", seg_evt, 1);

        // Asynchronous reset mid-pulse.
        clear_stim();
        set_high(0, 5);
        run_seg(5, 0);
        chk("arst_busy_before", busy, 1);
        sig = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_flags_now", {29'd0, evt, glitch, busy}, 0);
        sig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        w_hold = 0;
        clear_stim();
        run_seg(40, 1);
        chk("arst_evt_count", seg_evt, 0);

        // Random pulse trains.
        for (int r = 0; r < 3; r++) begin
            clear_stim();
            t = 5;
            while (t < 400) begin
                int l, g;
                l = $urandom_range(1, 12);
                g = $urandom_range(1, 25);
                set_high(t, l);
                t += l + g;
            end
            run_seg(t + 40, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
